// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and helpers for the dff_bank_arbiter slice.
// Optional feature macro used elsewhere in the slice: DFF_ARB_LOCK_EN.
package dff_arb_pkg;

    // FSM states of the arbiter: IDLE -> GRANT -> WRITE -> IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Ceiling log2, used for address and pointer widths (value >= 2 expected)
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the shared register bank: write handshake plus read port.
// With DFF_ARB_LOCK_EN defined, a per-requester lock input is added.
interface dff_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 2
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] wr_addr;
    logic [NUM_REQ*DATA_W-1:0] wr_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic [ADDR_W-1:0]         rd_addr;
    logic [DATA_W-1:0]         rd_data;
    logic                      busy;
`ifdef DFF_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        lock;
`endif

    // Requesting control blocks drive this side
    modport master (
        output req, wr_addr, wr_data, rd_addr,
`ifdef DFF_ARB_LOCK_EN
        output lock,
`endif
        input  gnt, ack, rd_data, busy
    );

    // The arbiter/bank drives this side
    modport slave (
        input  req, wr_addr, wr_data, rd_addr,
`ifdef DFF_ARB_LOCK_EN
        input  lock,
`endif
        output gnt, ack, rd_data, busy
    );

endinterface

// File: rtl/dff_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first set request strictly after the
// pointer position wins, wrapping from NUM_REQ-1 back to 0. Output is one-hot.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] winner
);

    // Scan requesters in priority order starting just after the pointer
    always_comb begin
        int   idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(pointer) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Shared bank of NUM_REGS registers written by NUM_REQ requesters through a
// round-robin req/gnt/ack handshake, one write per arbitration; combinational read.
// Optional feature: define DFF_ARB_LOCK_EN to let a locked winner burst writes.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              rst,
    dff_bank_arbiter_if.slave bus
);

    localparam int ADDR_W = clog2(NUM_REGS);
    localparam int PTR_W  = clog2(NUM_REQ);

    state_t              state_reg, state_next;
    logic [PTR_W-1:0]    win_idx_reg, win_idx_next;
    logic [PTR_W-1:0]    ptr_reg, ptr_next;
    logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]  ack_reg, ack_next;
    logic [ADDR_W-1:0]   hold_addr_reg, hold_addr_next;
    logic [DATA_W-1:0]   hold_data_reg, hold_data_next;
    logic                wr_en;
    logic                lock_hold;
    logic [NUM_REQ-1:0]  arb_onehot;
    logic [PTR_W-1:0]    arb_idx;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [DATA_W-1:0]   bank     [NUM_REGS];

    // Unpack the flattened per-requester address/data buses
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = bus.wr_addr[gi*ADDR_W +: ADDR_W];
        assign data_arr[gi] = bus.wr_data[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req     (bus.req),
        .pointer (ptr_reg),
        .winner  (arb_onehot)
    );

    // One-hot winner to index
    always_comb begin
        arb_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_onehot[k]) arb_idx = PTR_W'(k);
        end
    end

    // A locked winner that still requests goes straight back to GRANT
`ifdef DFF_ARB_LOCK_EN
    assign lock_hold = bus.lock[win_idx_reg] && bus.req[win_idx_reg];
`else
    assign lock_hold = 1'b0;
`endif

    // Next-state and registered-output logic of the handshake FSM
    always_comb begin
        state_next     = state_reg;
        win_idx_next   = win_idx_reg;
        ptr_next       = ptr_reg;
        gnt_next       = gnt_reg;
        ack_next       = '0;
        hold_addr_next = hold_addr_reg;
        hold_data_next = hold_data_reg;
        wr_en          = 1'b0;
        case (state_reg)
            IDLE: begin
                gnt_next = '0;
                if (|bus.req) begin
                    win_idx_next = arb_idx;
                    state_next   = GRANT;
                end
            end
            GRANT: begin
                if (bus.req[win_idx_reg]) begin
                    gnt_next              = '0;
                    gnt_next[win_idx_reg] = 1'b1;
                    hold_addr_next        = addr_arr[win_idx_reg];
                    hold_data_next        = data_arr[win_idx_reg];
                    state_next            = WRITE;
                end else begin
                    // Requester withdrew: abandon without writing, pointer kept
                    gnt_next   = '0;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                wr_en                 = 1'b1;
                ack_next[win_idx_reg] = 1'b1;
                if (lock_hold) begin
                    state_next = GRANT;
                end else begin
                    gnt_next   = '0;
                    ptr_next   = win_idx_reg;
                    state_next = IDLE;
                end
            end
            default: begin
                gnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // FSM state, pointer, grant/ack and hold registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            win_idx_reg   <= '0;
            ptr_reg       <= PTR_W'(NUM_REQ - 1);
            gnt_reg       <= '0;
            ack_reg       <= '0;
            hold_addr_reg <= '0;
            hold_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            win_idx_reg   <= win_idx_next;
            ptr_reg       <= ptr_next;
            gnt_reg       <= gnt_next;
            ack_reg       <= ack_next;
            hold_addr_reg <= hold_addr_next;
            hold_data_reg <= hold_data_next;
        end
    end

    // Register bank: each register cleared on reset, loaded when addressed in WRITE
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bank
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                bank[gi] <= '0;
            end else if (wr_en && (hold_addr_reg == ADDR_W'(gi))) begin
                bank[gi] <= hold_data_reg;
            end
        end
    end

    assign bus.gnt     = gnt_reg;
    assign bus.ack     = ack_reg;
    assign bus.busy    = (state_reg != IDLE);
    assign bus.rd_data = bank[bus.rd_addr];

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: directed steps plus randomized
// traffic checked against a transaction-level reference model.
module tb_dff_bank_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 2;
    localparam int NREG = 4;

    logic clk;
    logic rst;

    int total;
    int bad;

    logic [NREQ-1:0] req_v;
    logic [NREQ-1:0] lock_v;
    logic [AW-1:0]   addr_a [NREQ];
    logic [DW-1:0]   data_a [NREQ];

    // Reference model state
    logic [DW-1:0]   m_bank [NREG];
    int              m_ptr;

    dff_bank_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) ifc ();

    dff_bank_arbiter #(
        .NUM_REQ  (NREQ),
        .DATA_W   (DW),
        .NUM_REGS (NREG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            ifc.wr_addr[i*AW +: AW] = addr_a[i];
            ifc.wr_data[i*DW +: DW] = data_a[i];
        end
        ifc.req = req_v;
`ifdef DFF_ARB_LOCK_EN
        ifc.lock = lock_v;
`endif
    endtask

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: walk requesters in order starting after the pointer
    function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
        int order [$];
        for (int k = 1; k <= NREQ; k++) order.push_back((p + k) % NREQ);
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_bank[i] = '0;
        m_ptr = NREQ - 1;
    endtask

    task automatic raise(input int i);
        req_v[i]  = 1'b1;
        addr_a[i] = AW'($urandom_range(0, NREG - 1));
        data_a[i] = DW'($urandom);
    endtask

    // One complete transaction starting in IDLE with at least one request up
    task automatic do_txn(input string tag, input bit late_reqs);
        int w;
        w = model_pick(req_v, m_ptr);
        tick();
        check({tag, ".grant_busy"}, 32'(ifc.busy), 32'd1);
        check({tag, ".grant_gnt"}, 32'(ifc.gnt), 32'd0);
        if (late_reqs) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_v[i] && $urandom_range(0, 2) == 0) raise(i);
            end
            apply();
        end
        tick();
        check({tag, ".write_gnt"}, 32'(ifc.gnt), 32'(onehot(w)));
        check({tag, ".write_ack"}, 32'(ifc.ack), 32'd0);
        ifc.rd_addr = addr_a[w];
        #1;
        check({tag, ".write_old"}, 32'(ifc.rd_data), 32'(m_bank[addr_a[w]]));
        tick();
        m_bank[addr_a[w]] = data_a[w];
        m_ptr = w;
        check({tag, ".ack"}, 32'(ifc.ack), 32'(onehot(w)));
        check({tag, ".ack_gnt"}, 32'(ifc.gnt), 32'd0);
        check({tag, ".ack_busy"}, 32'(ifc.busy), 32'd0);
        check({tag, ".rd_new"}, 32'(ifc.rd_data), 32'(m_bank[addr_a[w]]));
        $display("txn %s: winner=%0d addr=%0d data=%02h", tag, w, addr_a[w], data_a[w]);
        req_v[w] = 1'b0;
        apply();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        lock_v = '0;
        req_v  = '0;
        for (int i = 0; i < NREQ; i++) raise(i);
        req_v  = NREQ'($urandom);
        ifc.rd_addr = '0;
        rst = 1'b0;
        apply();
        model_reset();

        // 1: reset with random inputs
        tick();
        tick();
        check("rst.gnt", 32'(ifc.gnt), 32'd0);
        check("rst.ack", 32'(ifc.ack), 32'd0);
        check("rst.busy", 32'(ifc.busy), 32'd0);
        for (int a = 0; a < NREG; a++) begin
            ifc.rd_addr = AW'(a);
            #1;
            check("rst.rd", 32'(ifc.rd_data), 32'd0);
        end
        $display("txn reset: outputs and bank checked");
        req_v = '0;
        apply();
        rst = 1'b1;
        tick();
        check("idle.busy", 32'(ifc.busy), 32'd0);

        // 2: single write from requester 2
        req_v = 4'b0100;
        addr_a[2] = 2'd3;
        data_a[2] = 8'hA5;
        apply();
        do_txn("single", 1'b0);
        check("single.a5", 32'(ifc.rd_data), 32'hA5);

        // 5: reset during WRITE abandons the write and clears the bank
        req_v = 4'b0001;
        addr_a[0] = 2'd3;
        data_a[0] = 8'h5A;
        apply();
        tick();
        tick();
        check("midrst.write_gnt", 32'(ifc.gnt), 32'b0001);
        rst = 1'b0;
        #1;
        check("midrst.gnt", 32'(ifc.gnt), 32'd0);
        check("midrst.busy", 32'(ifc.busy), 32'd0);
        ifc.rd_addr = 2'd3;
        #1;
        check("midrst.reg3", 32'(ifc.rd_data), 32'd0);
        tick();
        check("midrst.ack", 32'(ifc.ack), 32'd0);
        model_reset();
        req_v = '0;
        apply();
        rst = 1'b1;
        tick();
        check("midrst.idle", 32'(ifc.busy), 32'd0);
        $display("txn midrst: write abandoned");

        // 3: fairness with all four requesting, starting at requester 0
        for (int i = 0; i < NREQ; i++) raise(i);
        apply();
        for (int k = 0; k < NREQ; k++) do_txn($sformatf("fair%0d", k), 1'b0);

`ifdef DFF_ARB_LOCK_EN
        // 6: locked burst from requester 0 with requester 2 pending
        raise(0);
        raise(2);
        lock_v = 4'b0001;
        apply();
        tick();
        tick();
        check("lock.gnt1", 32'(ifc.gnt), 32'b0001);
        for (int b = 0; b < 3; b++) begin
            tick();
            check("lock.ack", 32'(ifc.ack), 32'b0001);
            check("lock.busy_or_gnt", 32'(ifc.gnt), (b < 2) ? 32'b0001 : 32'd0);
            m_bank[addr_a[0]] = data_a[0];
            ifc.rd_addr = addr_a[0];
            #1;
            check("lock.rd", 32'(ifc.rd_data), 32'(data_a[0]));
            $display("txn lock%0d: addr=%0d data=%02h", b, addr_a[0], data_a[0]);
            if (b < 2) begin
                addr_a[0] = AW'($urandom_range(0, NREG - 1));
                data_a[0] = DW'($urandom);
                if (b == 1) lock_v = '0;
                apply();
                tick();
                check("lock.write_gnt", 32'(ifc.gnt), 32'b0001);
                check("lock.write_ack", 32'(ifc.ack), 32'd0);
            end
        end
        m_ptr = 0;
        req_v[0] = 1'b0;
        apply();
        do_txn("lock_next", 1'b0);
`endif

        // 4: requester 1 withdraws in GRANT
        req_v = 4'b0010;
        raise(1);
        apply();
        tick();
        check("abort.busy", 32'(ifc.busy), 32'd1);
        req_v = '0;
        apply();
        tick();
        check("abort.gnt", 32'(ifc.gnt), 32'd0);
        check("abort.busy_idle", 32'(ifc.busy), 32'd0);
        tick();
        check("abort.ack", 32'(ifc.ack), 32'd0);
        for (int a = 0; a < NREG; a++) begin
            ifc.rd_addr = AW'(a);
            #1;
            check("abort.bank", 32'(ifc.rd_data), 32'(m_bank[a]));
        end
        $display("txn abort: no write");
        raise(1);
        raise(3);
        apply();
        do_txn("after_abort", 1'b0);

        // Randomized traffic, including requests arriving mid-transaction
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_v[i] && $urandom_range(0, 2) == 0) raise(i);
            end
            apply();
            if (req_v == '0) begin
                tick();
                check("rand.idle_busy", 32'(ifc.busy), 32'd0);
                $display("txn rand%0d: idle", it);
            end else begin
                do_txn($sformatf("rand%0d", it), 1'b1);
            end
            ifc.rd_addr = AW'($urandom_range(0, NREG - 1));
            #1;
            check("rand.rd", 32'(ifc.rd_data), 32'(m_bank[ifc.rd_addr]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
